spi_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `spi_master` byte engine between up to `NREQ` requesters. It grants one requester at a time, launches byte transfers through the master's `start`/`data_in` port, detects completion from the master's `cs` output, and returns the received byte to the granted requester. It also drives one per-device chip-select per requester, so a multi-byte burst keeps its device selected across bytes. It sits between the requester logic and a single `spi_master` instance at the top level.

---
 rtl/spi_arbiter.sv | 150 +++++++++++++++
 tb/tb_spi_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master byte engine between NREQ requesters.
// Define SPI_ARBITER_BURST_EN to keep a device selected across a multi-byte burst.
module spi_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     last,
  input  logic [8*NREQ-1:0]   tx_data,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rx_valid,
  output logic [7:0]          rx_data,
  output logic [NREQ-1:0]     dev_cs_n,
  output logic                m_start,
  output logic [7:0]          m_data_in,
  input  logic                m_cs,
  input  logic [7:0]          m_data_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_SEL, XFER, DONE, HOLD, GAP} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d;
  logic [IW-1:0]   cur, cur_d;
  logic [IW-1:0]   sel;
  logic            last_q, last_q_d;
  logic            launch, to_gap;
  logic [NREQ-1:0] gnt_d, rx_valid_d, dev_cs_n_d;
  logic [7:0]      rx_data_d, m_data_in_d;
  logic            m_start_d;

  // Scanning from the farthest offset down leaves the nearest set bit after ptr as the winner.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    int idx;
    rr_pick = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (r[idx]) rr_pick = IW'(idx);
    end
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] v);
    next_idx = (v == IW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

`ifndef SPI_ARBITER_BURST_EN
  logic unused_last;
  assign unused_last = ^last;
`endif

  // NOTE: defaults first so every path assigns every signal; a missed branch would infer a latch.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cur_d       = cur;
    last_q_d    = last_q;
    gnt_d       = gnt;
    rx_valid_d  = '0;
    rx_data_d   = rx_data;
    dev_cs_n_d  = dev_cs_n;
    m_start_d   = 1'b0;
    m_data_in_d = m_data_in;
    sel         = cur;
    launch      = 1'b0;
    to_gap      = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          sel    = rr_pick(req, ptr);
          launch = 1'b1;
        end
      end
      LAUNCH:   state_d = WAIT_SEL;
      WAIT_SEL: if (!m_cs) state_d = XFER;
      XFER: begin
        if (m_cs) begin
          rx_data_d       = m_data_out;
          rx_valid_d[cur] = 1'b1;
          state_d         = DONE;
        end
      end
      DONE: begin
        if (last_q) to_gap = 1'b1;
        else        state_d = HOLD;
      end
      HOLD: begin
        if (req[cur]) launch = 1'b1;
        else          to_gap = 1'b1;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A continuing burst relaunches with the same device; its select is rewritten low, never pulsed.
    if (launch) begin
      state_d         = LAUNCH;
      cur_d           = sel;
      gnt_d           = '0;
      gnt_d[sel]      = 1'b1;
      dev_cs_n_d      = '1;
      dev_cs_n_d[sel] = 1'b0;
      m_start_d       = 1'b1;
      m_data_in_d     = tx_data[8*sel +: 8];
`ifdef SPI_ARBITER_BURST_EN
      last_q_d        = last[sel];
`else
      last_q_d        = 1'b1;
`endif
    end

    if (to_gap) begin
      state_d    = GAP;
      gnt_d      = '0;
      dev_cs_n_d = '1;
      ptr_d      = next_idx(cur);
    end
  end

  // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      last_q    <= 1'b0;
      gnt       <= '0;
      rx_valid  <= '0;
      rx_data   <= '0;
      dev_cs_n  <= '1;
      m_start   <= 1'b0;
      m_data_in <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cur       <= cur_d;
      last_q    <= last_q_d;
      gnt       <= gnt_d;
      rx_valid  <= rx_valid_d;
      rx_data   <= rx_data_d;
      dev_cs_n  <= dev_cs_n_d;
      m_start   <= m_start_d;
      m_data_in <= m_data_in_d;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a loopback spi_master stand-in; expectations follow
// SPI_ARBITER_BURST_EN when it is defined for the build.
module tb_spi_arbiter;

  localparam int NREQ   = 4;
  localparam int SHIFT  = 8;
  localparam int BUDGET = 300;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   last = '0;
  logic [8*NREQ-1:0] tx_data = '0;
  logic [NREQ-1:0]   gnt, rx_valid, dev_cs_n;
  logic [7:0]        rx_data, m_data_in, m_data_out;
  logic              m_start, m_cs;

  always #5 clk = ~clk;

  spi_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .tx_data(tx_data),
    .gnt(gnt), .rx_valid(rx_valid), .rx_data(rx_data), .dev_cs_n(dev_cs_n),
    .m_start(m_start), .m_data_in(m_data_in), .m_cs(m_cs), .m_data_out(m_data_out)
  );

  // Loopback master: cs low for SHIFT cycles, then the sent byte comes back on data_out.
  logic [7:0] m_shreg;
  int         m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cs <= 1'b1; m_cnt <= 0; m_shreg <= '0; m_data_out <= '0;
    end else if (m_cs) begin
      if (m_start) begin m_cs <= 1'b0; m_cnt <= SHIFT; m_shreg <= m_data_in; end
    end else if (m_cnt <= 1) begin
      m_cs <= 1'b1; m_data_out <= m_shreg;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  int errors = 0, checks = 0, viol = 0;
  int start_log[$];
  int rx_idx[$];
  logic [7:0] rx_byte[$];
  int windows[NREQ];
  logic [NREQ-1:0] prev_rx = '0, prev_cs = '1;
  logic [7:0] plan_data[NREQ][4];
  logic       plan_last[NREQ][4];
  int pos[NREQ], len[NREQ];

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One cycle: sample at the falling edge, log events, then let requesters react.
  task automatic step();
    @(negedge clk);
    if (!$onehot0(gnt) || dev_cs_n !== ~gnt || (rx_valid & ~gnt) != '0 ||
        !$onehot0(rx_valid) || (rx_valid & prev_rx) != '0) viol++;
    if (m_start) start_log.push_back(idx_of(gnt));
    if (rx_valid != '0) begin rx_idx.push_back(idx_of(rx_valid)); rx_byte.push_back(rx_data); end
    for (int i = 0; i < NREQ; i++) if (prev_cs[i] && !dev_cs_n[i]) windows[i]++;
    prev_rx = rx_valid;
    prev_cs = dev_cs_n;
    for (int i = 0; i < NREQ; i++) begin
      if (rx_valid[i] && req[i]) begin
        pos[i]++;
        if (pos[i] >= len[i]) req[i] = 1'b0;
        else begin
          tx_data[8*i +: 8] = plan_data[i][pos[i]];
          last[i]           = plan_last[i][pos[i]];
        end
      end
    end
  endtask

  task automatic launch_req(input int i, input int n);
    pos[i] = 0; len[i] = n;
    tx_data[8*i +: 8] = plan_data[i][0];
    last[i] = plan_last[i][0];
    req[i] = 1'b1;
  endtask

  task automatic wait_rx(input int target, input string name);
    int n = 0;
    while (rx_byte.size() < target && n < BUDGET) begin step(); n++; end
    checks++;
    if (rx_byte.size() < target) begin
      errors++; $display("FAIL %s: rx pulses got %0d expected %0d", name, rx_byte.size(), target);
    end
  endtask

  task automatic wait_cs(input logic val, input string name);
    int n = 0;
    while (m_cs !== val && n < BUDGET) begin step(); n++; end
    checks++;
    if (m_cs !== val) begin errors++; $display("FAIL %s: m_cs got %b expected %b", name, m_cs, val); end
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (rx_valid !== 4'b0000) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0000", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (dev_cs_n !== 4'b1111) begin errors++; $display("FAIL reset_cs: got %b expected 1111", dev_cs_n); end
    checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL reset_m_start: got %b expected 0", m_start); end
    checks++; if (m_data_in !== 8'h00) begin errors++; $display("FAIL reset_m_data_in: got %h expected 00", m_data_in); end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_contention();
    int s0 = start_log.size();
    int r0 = rx_byte.size();
    int exp_g[3] = '{0, 2, 0};
    logic [7:0] exp_b[3] = '{8'h11, 8'h22, 8'h11};
    plan_data[0][0] = 8'h11; plan_last[0][0] = 1'b1;
    plan_data[2][0] = 8'h22; plan_last[2][0] = 1'b1;
    launch_req(0, 1);
    launch_req(2, 1);
    wait_rx(r0 + 1, "contention_first");
    repeat (2) step();
    launch_req(0, 1);
    wait_rx(r0 + 3, "contention_all");
    repeat (4) step();
    checks++;
    if (start_log.size() - s0 != 3) begin
      errors++; $display("FAIL contention_starts: got %0d expected 3", start_log.size() - s0);
    end
    for (int k = 0; k < 3; k++) begin
      int g = (s0 + k < start_log.size()) ? start_log[s0 + k] : -1;
      logic [7:0] b = (r0 + k < rx_byte.size()) ? rx_byte[r0 + k] : 8'hxx;
      checks++;
      if (g != exp_g[k]) begin errors++; $display("FAIL contention_grant[%0d]: got %0d expected %0d", k, g, exp_g[k]); end
      checks++;
      if (b !== exp_b[k]) begin errors++; $display("FAIL contention_rx[%0d]: got %h expected %h", k, b, exp_b[k]); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL contention_invariants: got %0d violations expected 0", viol); end
  endtask

  task automatic test_single();
    int r0 = rx_byte.size();
    plan_data[0][0] = 8'hA5; plan_last[0][0] = 1'b1;
    launch_req(0, 1);
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    checks++; if (dev_cs_n !== 4'b1110) begin errors++; $display("FAIL single_cs: got %b expected 1110", dev_cs_n); end
    checks++; if (m_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", m_start); end
    checks++; if (m_data_in !== 8'hA5) begin errors++; $display("FAIL single_data_in: got %h expected a5", m_data_in); end
    step();
    checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b expected 0", m_start); end
    checks++; if (m_cs !== 1'b0) begin errors++; $display("FAIL single_m_cs_fall: got %b expected 0", m_cs); end
    wait_cs(1'b1, "single_m_cs_rise");
    step();
    checks++; if (rx_valid !== 4'b0001) begin errors++; $display("FAIL single_rx_valid: got %b expected 0001", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data: got %h expected a5", rx_data); end
    repeat (3) step();
    checks++; if (dev_cs_n !== 4'b1111) begin errors++; $display("FAIL single_cs_after: got %b expected 1111", dev_cs_n); end
    checks++; if (rx_byte.size() - r0 != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", rx_byte.size() - r0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_hold: got %h expected a5", rx_data); end
  endtask

  task automatic test_burst();
    int s0 = start_log.size();
    int r0 = rx_byte.size();
    int w1 = windows[1];
`ifdef SPI_ARBITER_BURST_EN
    int exp_g[4] = '{1, 1, 1, 3};
    logic [7:0] exp_b[4] = '{8'h01, 8'h02, 8'h03, 8'h33};
    int exp_w = 1;
`else
    int exp_g[4] = '{1, 1, 3, 1};
    logic [7:0] exp_b[4] = '{8'h01, 8'h02, 8'h33, 8'h03};
    int exp_w = 3;
`endif
    plan_data[1][0] = 8'h01; plan_last[1][0] = 1'b0;
    plan_data[1][1] = 8'h02; plan_last[1][1] = 1'b0;
    plan_data[1][2] = 8'h03; plan_last[1][2] = 1'b1;
    plan_data[3][0] = 8'h33; plan_last[3][0] = 1'b1;
    launch_req(1, 3);
    wait_rx(r0 + 1, "burst_first");
    repeat (3) step();
    launch_req(3, 1);
    wait_rx(r0 + 4, "burst_all");
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      int g = (s0 + k < start_log.size()) ? start_log[s0 + k] : -1;
      logic [7:0] b = (r0 + k < rx_byte.size()) ? rx_byte[r0 + k] : 8'hxx;
      checks++;
      if (g != exp_g[k]) begin errors++; $display("FAIL burst_grant[%0d]: got %0d expected %0d", k, g, exp_g[k]); end
      checks++;
      if (b !== exp_b[k]) begin errors++; $display("FAIL burst_rx[%0d]: got %h expected %h", k, b, exp_b[k]); end
    end
    checks++;
    if (windows[1] - w1 != exp_w) begin
      errors++; $display("FAIL burst_cs_windows: got %0d expected %0d", windows[1] - w1, exp_w);
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL burst_invariants: got %0d violations expected 0", viol); end
  endtask

  task automatic test_early_drop();
    int s0 = start_log.size();
    int r0 = rx_byte.size();
    int w1 = windows[1];
    plan_data[1][0] = 8'h5A; plan_last[1][0] = 1'b0;
    launch_req(1, 1);
    wait_rx(r0 + 1, "drop_rx");
    repeat (10) step();
    checks++; if (start_log.size() - s0 != 1) begin errors++; $display("FAIL drop_starts: got %0d expected 1", start_log.size() - s0); end
    checks++; if (dev_cs_n[1] !== 1'b1) begin errors++; $display("FAIL drop_cs: got %b expected 1", dev_cs_n[1]); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_gnt: got %b expected 0000", gnt); end
    checks++; if (windows[1] - w1 != 1) begin errors++; $display("FAIL drop_windows: got %0d expected 1", windows[1] - w1); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL drop_rx_data: got %h expected 5a", rx_data); end
  endtask

  task automatic test_reset_mid_xfer();
    int r0;
    plan_data[2][0] = 8'h77; plan_last[2][0] = 1'b1;
    launch_req(2, 1);
    wait_cs(1'b0, "rst_mid_cs_low");
    repeat (2) step();
    rst_n = 1'b0;
    req = '0; len[2] = 0;
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 0000", gnt); end
    checks++; if (dev_cs_n !== 4'b1111) begin errors++; $display("FAIL rst_mid_cs: got %b expected 1111", dev_cs_n); end
    checks++; if (rx_valid !== 4'b0000) begin errors++; $display("FAIL rst_mid_rx_valid: got %b expected 0000", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_data: got %h expected 00", rx_data); end
    rst_n = 1'b1;
    repeat (2) step();
    r0 = rx_byte.size();
    plan_data[2][0] = 8'h3C; plan_last[2][0] = 1'b1;
    launch_req(2, 1);
    wait_rx(r0 + 1, "rst_mid_recover");
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rst_mid_recover_data: got %h expected 3c", rx_data); end
    checks++;
    if (r0 < rx_idx.size() && rx_idx[r0] != 2) begin
      errors++; $display("FAIL rst_mid_recover_idx: got %0d expected 2", rx_idx[r0]);
    end
    repeat (3) step();
    checks++; if (dev_cs_n !== 4'b1111) begin errors++; $display("FAIL rst_mid_cs_after: got %b expected 1111", dev_cs_n); end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin windows[i] = 0; pos[i] = 0; len[i] = 0; end
    test_reset();
    test_contention();
    test_single();
    test_burst();
    test_early_drop();
    test_reset_mid_xfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
